seq_mag_cmp: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Operands are captured on a start strobe and compared SLICE bits per cycle, MSB slice first, with early termination.
- Equal operands resolve through a 3-bit cascade input, using the same gt/eq/lt cascade rules as the team's 4-bit comparator.
- Serves as the wide, pipelined-datapath successor where a combinational wide compare would break timing.

---
 rtl/seq_mag_cmp.sv | 74 +++++++
 tb/tb_seq_mag_cmp.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: multi-cycle MSB-slice-first magnitude comparator with {gt,eq,lt} cascade input.
// Define CMP_SIGNED_EN to add a Signed port selecting two's-complement operands.
module seq_mag_cmp #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] DateA,
   input  logic [WIDTH-1:0] DateB,
   input  logic [2:0]       Cas,
`ifdef CMP_SIGNED_EN
   input  logic             Signed,
`endif
   output logic             busy,
   output logic             done,
   output logic [2:0]       Q
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state;
   logic [WIDTH-1:0] a, b;
   logic [2:0]       cas, res;
   logic [IW-1:0]    idx;
   logic [SLICE-1:0] sa, sb, flip;
`ifdef CMP_SIGNED_EN
   logic sgn;
   // inverting the sign bit of the top slice turns a two's-complement compare into an unsigned one
   assign flip = (sgn && idx == TOP) ? SLICE'(1) << (SLICE - 1) : '0;
`else
   assign flip = '0;
`endif
   assign sa  = a[int'(idx) * SLICE +: SLICE] ^ flip;
   assign sb  = b[int'(idx) * SLICE +: SLICE] ^ flip;
   assign res = cas[1] ? 3'b010 : cas == 3'b000 ? 3'b101 : cas == 3'b101 ? 3'b000 : cas;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Q     <= 3'b000;
         idx   <= '0;
         a     <= '0;
         b     <= '0;
         cas   <= 3'b000;
`ifdef CMP_SIGNED_EN
         sgn   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a     <= DateA;
               b     <= DateB;
               cas   <= Cas;
`ifdef CMP_SIGNED_EN
               sgn   <= Signed;
`endif
               idx   <= TOP;
               busy  <= 1'b1;
               state <= RUN;
            end
         end else if (sa != sb || idx == '0) begin
            Q     <= sa > sb ? 3'b100 : sa < sb ? 3'b001 : res;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
         end else
            idx <= idx - 1'b1;
      end
endmodule

// File: tb/tb_seq_mag_cmp.sv
// tb_seq_mag_cmp: randomized scoreboard bench for seq_mag_cmp (WIDTH=16, SLICE=4).
module tb_seq_mag_cmp;
   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int NSLICE = WIDTH / SLICE;
   typedef struct {
      logic [2:0] q;
      int         at;
   } exp_t;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] DateA = '0, DateB = '0;
   logic [2:0]       Cas = 3'b000;
   logic             Signed = 1'b0;
   logic             busy, done;
   logic [2:0]       Q;
   exp_t             sb[$];
   int               n_cmp = 0, n_bad = 0, cyc = 0;
   logic [2:0]       last_q = 3'b000;

   seq_mag_cmp #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .DateA(DateA), .DateB(DateB), .Cas(Cas),
`ifdef CMP_SIGNED_EN
      .Signed(Signed),
`endif
      .busy(busy), .done(done), .Q(Q));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] casc(input logic [2:0] c);
      case (c)
         3'b000:  return 3'b101;
         3'b101:  return 3'b000;
         3'b100:  return 3'b100;
         3'b001:  return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [2:0] model_q(input logic [WIDTH-1:0] a, b, input logic [2:0] c, input logic s);
      int ia, ib;
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      return ia > ib ? 3'b100 : ia < ib ? 3'b001 : casc(c);
   endfunction

   // cycles = number of slices examined until the first differing one, counted from the top
   function automatic int model_lat(input logic [WIDTH-1:0] a, b);
      logic [WIDTH-1:0] d;
      d = a ^ b;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (d[i]) return NSLICE - i / SLICE;
      return NSLICE;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) last_q = 3'b000;
      else if (done) begin
         if (sb.size() == 0) chk("unexpected_done", 32'(done), 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("q", 32'(Q), 32'(e.q));
            chk("done_edge", cyc, e.at);
            chk("busy_in_done", 32'(busy), 0);
         end
         last_q = Q;
      end else chk("q_hold", 32'(Q), 32'(last_q));
   end

   // drives noise (ignored starts, operand toggles) while busy, then issues the request
   task automatic issue(input logic [WIDTH-1:0] a, b, input logic [2:0] c, input logic s);
      int n = 0;
      logic se;
`ifdef CMP_SIGNED_EN
      se = s;
`else
      se = 1'b0;
`endif
      while (busy && n < 100) begin
         start  = 1'($urandom);
         DateA  = WIDTH'($urandom);
         DateB  = WIDTH'($urandom);
         Cas    = 3'($urandom);
         Signed = 1'($urandom);
         @(negedge clk);
         n++;
      end
      if (busy) chk("busy_timeout", 32'(busy), 0);
      DateA = a; DateB = b; Cas = c; Signed = s; start = 1'b1;
      sb.push_back('{q: model_q(a, b, c, se), at: cyc + 1 + model_lat(a, b)});
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int n;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_q", 32'(Q), 0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(16'h8000, 16'h7FFF, 3'b010, 1'b0);
      issue(16'h1234, 16'h1235, 3'b010, 1'b0);
      for (int c = 0; c < 8; c++) issue(16'hABCD, 16'hABCD, 3'(c), 1'b0);
      issue(16'h00F0, 16'h00F1, 3'b010, 1'b0);
      issue(16'h9000, 16'h1000, 3'b010, 1'b0);
      issue(16'h8000, 16'h0001, 3'b010, 1'b1);
      issue(16'h8000, 16'h0001, 3'b010, 1'b0);
      issue(16'hFFFF, 16'h7FFF, 3'b000, 1'b1);
      // abandon a comparison with an asynchronous reset
      issue(16'h5555, 16'h5555, 3'b100, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_q", 32'(Q), 0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(16'h0001, 16'h0002, 3'b010, 1'b0);
      for (int i = 0; i < 300; i++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 4))
            0:       rb = ra;
            4:       rb = WIDTH'($urandom);
            default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
         endcase
         issue(ra, rb, 3'($urandom), 1'($urandom));
      end
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) chk("drain", sb.size(), 0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
